// File: rtl/exp_align_pipe_pkg.sv
// Shared defaults and lane-slice helpers for the exponent alignment pipeline.
package exp_align_pipe_pkg;

    localparam int LANES_DEF = 16;
    localparam int WIDTH_DEF = 52;
    localparam int EXP_W_DEF = 10;

    // LSB position of lane `lane` inside a vector packed with `lane_w`-bit lanes.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/align_lane_shift.sv
// One lane of the aligner: saturating arithmetic right shift plus sticky of discarded bits.
module align_lane_shift #(
    parameter int WIDTH = 52,
    parameter int EXP_W = 10
) (
    input  logic [WIDTH:0]   data_i,
    input  logic [EXP_W-1:0] shamt_i,
    output logic [WIDTH:0]   data_o,
    output logic             sticky_o
);

    localparam int DW = WIDTH + 1;

    logic [31:0]           shamt_ext;
    logic                  saturate;
    logic signed [WIDTH:0] data_s;
    logic [WIDTH:0]        shifted;
    logic [WIDTH:0]        drop_mask;

    assign shamt_ext = 32'(shamt_i);
    assign saturate  = (shamt_ext >= 32'(DW));
    assign data_s    = data_i;
    assign shifted   = data_s >>> shamt_ext;
    // Ones over exactly the bits that fall off the bottom; empty for a zero shift.
    assign drop_mask = ~({DW{1'b1}} << shamt_ext);

    assign data_o   = saturate ? {DW{data_i[WIDTH]}} : shifted;
    assign sticky_o = saturate ? (|data_i) : (|(data_i & drop_mask));

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage multi-lane exponent aligner: S1 captures the beat and its max exponent,
// S2 captures the per-lane shifted data and sticky bits. Valid/ready at both ends.
module exp_align_pipe
    import exp_align_pipe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*(WIDTH+1)-1:0] in_data,
    input  logic [LANES*EXP_W-1:0]     in_exp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*(WIDTH+1)-1:0] out_data,
    output logic [LANES-1:0]           out_sticky,
    output logic [EXP_W-1:0]           out_max_exp
);

    localparam int DW         = WIDTH + 1;
    localparam int TREE_DEPTH = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int NLEAF      = 1 << TREE_DEPTH;

    logic                    s1_valid_q;
    logic                    s1_mode_q;
    logic [LANES*DW-1:0]     s1_data_q;
    logic [LANES*EXP_W-1:0]  s1_exp_q;
    logic [EXP_W-1:0]        s1_max_q;
    logic [EXP_W-1:0]        max_exp_d;
    logic [EXP_W-1:0]        s1_max_d;

    logic                    out_valid_q;
    logic [LANES*DW-1:0]     out_data_q;
    logic [LANES-1:0]        out_sticky_q;
    logic [EXP_W-1:0]        out_max_q;
    logic [LANES*DW-1:0]     shifted_d;
    logic [LANES-1:0]        sticky_d;

    logic                    s2_ready;
    logic                    s1_ready;

    assign s2_ready = !out_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    // Balanced pairwise max tree; leaves beyond LANES are padded with zero exponents.
    always_comb begin
        logic [EXP_W-1:0] node [NLEAF];
        for (int i = 0; i < NLEAF; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            node[i] = in_exp[lane_lsb(i, EXP_W) +: EXP_W];
        end
        for (int span = NLEAF / 2; span >= 1; span = span / 2) begin
            for (int i = 0; i < span; i++) begin
                node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
            end
        end
        max_exp_d = node[0];
    end

    assign s1_max_d = mode ? max_exp_d : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_exp_q   <= '0;
            s1_max_q   <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= mode;
                s1_data_q <= in_data;
                s1_exp_q  <= in_exp;
                s1_max_q  <= s1_max_d;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [EXP_W-1:0] exp_lane;
            logic [EXP_W-1:0] shamt;

            assign exp_lane = s1_exp_q[lane_lsb(gi, EXP_W) +: EXP_W];
            // The max comes from the same beat, so the subtraction never wraps.
            assign shamt    = s1_mode_q ? (s1_max_q - exp_lane) : exp_lane;

            align_lane_shift #(
                .WIDTH (WIDTH),
                .EXP_W (EXP_W)
            ) u_shift (
                .data_i   (s1_data_q[lane_lsb(gi, DW) +: DW]),
                .shamt_i  (shamt),
                .data_o   (shifted_d[lane_lsb(gi, DW) +: DW]),
                .sticky_o (sticky_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sticky_q <= '0;
            out_max_q    <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= shifted_d;
                out_sticky_q <= sticky_d;
                out_max_q    <= s1_max_q;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sticky  = out_sticky_q;
    assign out_max_exp = out_max_q;

endmodule

// File: doc/exp_align_pipe.md
EXP_ALIGN_PIPE -- requirements
Module: exp_align_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16: number of parallel lanes.
REQ-002 SHALL have parameter WIDTH, default 52: each lane datum is WIDTH+1 bits, signed two's complement.
REQ-003 SHALL have parameter EXP_W, default 10: exponent and shift-amount width, unsigned.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port mode, input, 1: 1 = max-exponent alignment; 0 = direct per-lane shift.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat when in_valid && in_ready.
REQ-009 SHALL have port in_data, input, LANES*(WIDTH+1): lane i at bits [i*(WIDTH+1) +: WIDTH+1].
REQ-010 SHALL have port in_exp, input, LANES*EXP_W: lane i at bits [i*EXP_W +: EXP_W]; an exponent when mode=1, a shift amount when mode=0.
REQ-011 SHALL have port out_valid, output, 1: output beat valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, LANES*(WIDTH+1): aligned lanes, same packing as in_data.
REQ-014 SHALL have port out_sticky, output, LANES: per-lane OR of all bits discarded by the shift.
REQ-015 SHALL have port out_max_exp, output, EXP_W: the max in_exp of the beat when mode=1; 0 when mode=0.

Function
REQ-016 SHALL be a two-stage pipeline. S1 registers data, exps, mode and the max exponent from a comparator tree. S2 registers the shifted data and sticky bits.
REQ-017 SHALL sample mode with each accepted beat; mode changes never affect beats already in flight.
REQ-018 SHALL compute the lane-i shift as max_exp - exp_i when mode=1, and as exp_i when mode=0.
REQ-019 SHALL perform an arithmetic right shift of each lane by its shift amount, replicating the sign bit.
REQ-020 SHALL saturate any shift >= WIDTH+1: data becomes all sign bits (0 or all ones), and sticky = OR of the entire input lane.
REQ-021 SHALL produce sticky = 0 for a shift of 0.
REQ-022 SHALL produce a beat on out_valid exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-023 SHALL sustain a throughput of one beat per cycle with no bubbles.
REQ-024 SHALL drive the ready chain as: s2_ready = !out_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready. in_ready is combinational on out_ready.
REQ-025 SHALL hold out_data, out_sticky and out_max_exp stable while out_valid && !out_ready; a stalled stage holds its contents.
REQ-026 SHALL, when a stage is simultaneously drained and refilled in one cycle, take the new beat with no loss or duplication.
REQ-027 SHALL preserve beat order; it drops no beats and invents none.
REQ-028 SHALL, when lanes tie for max exponent, give each tied lane shift 0.

Reset
REQ-029 SHALL, when rst is asserted (asynchronously), clear s1_valid and out_valid to 0, and clear out_data, out_sticky and out_max_exp to 0.
REQ-030 SHALL drop any in-flight beats on mid-operation reset; in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL take the default LANES, WIDTH and EXP_W values, and the lane-slice index helpers, from the shared PE package.
REQ-032 SHALL put the per-lane saturating shift-plus-sticky logic in one sub-module, align_lane_shift, instantiated LANES times.
REQ-033 SHALL use a combinational max tree of depth ceil(log2(LANES)) inside S1.

Verification
REQ-034 SHALL cover: mode=1, exps all 0x100 except lane3 = 0x0FE, lane3 data = 0x00000000000005 -> lane3 out = 0x1, sticky = 1; other lanes unchanged, sticky = 0; out_max_exp = 0x100.
REQ-035 SHALL cover: mode=1, lane0 exp = 0x000, lane1 exp = 0x3FF, lane0 data = -1 (all ones) -> lane0 out = all ones (saturated), sticky = 1.
REQ-036 SHALL cover: mode=0, lane5 shift = 4, data = 0x10000000000000 (sign set) -> out = 0x1F000000000000, sticky = 0; out_max_exp = 0.
REQ-037 SHALL cover: 20 back-to-back beats with out_ready = 1 -> 20 outputs in order, first output 2 cycles after the first accept, none missing.
REQ-038 SHALL cover: out_ready = 0 for 5 cycles during streaming -> in_ready falls after 2 beats buffered; outputs held stable; order preserved on release.
REQ-039 SHALL cover: rst pulse with 2 beats in flight -> out_valid = 0 immediately; no stale beat appears after release.
